// File: rtl/ux607_i2c_master_byte_seq_pkg.sv
// Shared definitions for the I2C master byte sequencer.
// - Bit-controller command encodings (one-hot, NOP = all zero).
// - Byte FSM state type.
package ux607_i2c_master_byte_seq_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } byte_state_e;

endpackage

// File: rtl/ux607_i2c_byte_shreg.sv
// Byte shift register with bit down-counter for the I2C byte sequencer.
// Ports:
//   clk, nReset    : clock, synchronous active-low reset
//   ld             : load din into the register, counter to DW-1
//   shift          : shift rxd in at the LSB, decrement the counter
//   din            : byte to load
//   rxd            : bit to shift in
//   sr             : register contents (MSB is the bit on the wire)
//   cnt_done       : counter is zero (last bit of the byte in flight)
module ux607_i2c_byte_shreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          ld,
  input  logic          shift,
  input  logic [DW-1:0] din,
  input  logic          rxd,
  output logic [DW-1:0] sr,
  output logic          cnt_done
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (ld) begin
      sr_d  = din;
      cnt_d = CW'(DW - 1);
    end else if (shift) begin
      sr_d  = {sr_q[DW-2:0], rxd};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr       = sr_q;
  assign cnt_done = (cnt_q == '0);

endmodule

// File: rtl/ux607_i2c_master_byte_seq.sv
// I2C master byte sequencer: turns host start/write/read/stop requests into
// the bit-controller command stream and shifts 8 data bits plus ACK.
// Ports:
//   clk, nReset                 : clock, synchronous active-low reset
//   start/stop/read/write       : host request bits, held until cmd_ack
//   ack_in                      : ACK the master drives after a read
//   din / dout                  : byte to send / shift register contents
//   cmd_ack                     : one-cycle completion pulse
//   ack_out                     : ACK bit sampled in the 9th clock
//   i2c_al                      : one-cycle arbitration-lost pulse
//   core_cmd/core_txd           : command and data bit to bit controller
//   core_ack/core_rxd/core_al   : bit controller done, sampled bit, arb lost
module ux607_i2c_master_byte_seq
  import ux607_i2c_master_byte_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          stop,
  input  logic          read,
  input  logic          write,
  input  logic          ack_in,
  input  logic [DW-1:0] din,
  output logic          cmd_ack,
  output logic          ack_out,
  output logic [DW-1:0] dout,
  output logic          i2c_al,
  output logic [3:0]    core_cmd,
  output logic          core_txd,
  input  logic          core_ack,
  input  logic          core_rxd,
  input  logic          core_al
);

  byte_state_e   state_q, state_d;
  logic [3:0]    core_cmd_q, core_cmd_d;
  logic          core_txd_q, core_txd_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          ack_out_q, ack_out_d;
  logic          i2c_al_q, i2c_al_d;
  logic          ld, shift, cnt_done, go;
  logic [DW-1:0] sr;

  ux607_i2c_byte_shreg #(.DW(DW)) u_shreg (
    .clk      (clk),
    .nReset   (nReset),
    .ld       (ld),
    .shift    (shift),
    .din      (din),
    .rxd      (core_rxd),
    .sr       (sr),
    .cnt_done (cnt_done)
  );

  // The request bits are still high during the cmd_ack cycle; masking with
  // cmd_ack keeps a finished request from being started a second time.
  assign go = (read | write | stop) & ~cmd_ack_q;

  always_comb begin
    state_d    = state_q;
    core_cmd_d = core_cmd_q;
    core_txd_d = core_txd_q;
    ack_out_d  = ack_out_q;
    cmd_ack_d  = 1'b0;
    i2c_al_d   = 1'b0;
    ld         = 1'b0;
    shift      = 1'b0;

    // Arbitration loss overrides everything, including a coincident core_ack.
    if (core_al) begin
      state_d    = ST_IDLE;
      core_cmd_d = I2C_CMD_NOP;
      core_txd_d = 1'b0;
      i2c_al_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            ld         = 1'b1;
            core_txd_d = din[DW-1];
            if (start) begin
              state_d    = ST_START;
              core_cmd_d = I2C_CMD_START;
            end else if (read) begin
              state_d    = ST_READ;
              core_cmd_d = I2C_CMD_READ;
            end else if (write) begin
              state_d    = ST_WRITE;
              core_cmd_d = I2C_CMD_WRITE;
            end else begin
              state_d    = ST_STOP;
              core_cmd_d = I2C_CMD_STOP;
            end
          end
        end
        ST_START: begin
          if (core_ack) begin
            ld         = 1'b1;
            core_txd_d = din[DW-1];
            if (read) begin
              state_d    = ST_READ;
              core_cmd_d = I2C_CMD_READ;
            end else begin
              state_d    = ST_WRITE;
              core_cmd_d = I2C_CMD_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (core_ack) begin
            shift = 1'b1;
            if (cnt_done) begin
              // Release SDA for the slave's ACK bit by issuing a read.
              state_d    = ST_ACK;
              core_cmd_d = I2C_CMD_READ;
            end else begin
              core_cmd_d = I2C_CMD_WRITE;
              core_txd_d = sr[DW-2];
            end
          end
        end
        ST_READ: begin
          if (core_ack) begin
            shift = 1'b1;
            if (cnt_done) begin
              state_d    = ST_ACK;
              core_cmd_d = I2C_CMD_WRITE;
              core_txd_d = ack_in;
            end else begin
              core_cmd_d = I2C_CMD_READ;
              core_txd_d = sr[DW-2];
            end
          end
        end
        ST_ACK: begin
          if (core_ack) begin
            ack_out_d  = core_rxd;
            core_txd_d = 1'b1;
            if (stop) begin
              state_d    = ST_STOP;
              core_cmd_d = I2C_CMD_STOP;
            end else begin
              state_d    = ST_IDLE;
              core_cmd_d = I2C_CMD_NOP;
              cmd_ack_d  = 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (core_ack) begin
            state_d    = ST_IDLE;
            core_cmd_d = I2C_CMD_NOP;
            cmd_ack_d  = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          core_cmd_d = I2C_CMD_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      core_cmd_q <= I2C_CMD_NOP;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
      i2c_al_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
      i2c_al_q   <= i2c_al_d;
    end
  end

  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign i2c_al   = i2c_al_q;
  assign core_cmd = core_cmd_q;
  assign core_txd = core_txd_q;
  assign dout     = sr;

endmodule

// File: tb/tb_ux607_i2c_master_byte_seq.sv
// Directed bench for the I2C master byte sequencer. A small bit-controller
// stand-in acknowledges each command one cycle after sampling it.
module tb_ux607_i2c_master_byte_seq;

  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  logic       clk = 1'b0;
  logic       nReset, start, stop, read, write, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out, i2c_al;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_txd, core_ack, core_rxd, core_al;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ux607_i2c_master_byte_seq #(.DW(8)) dut (
    .clk      (clk),
    .nReset   (nReset),
    .start    (start),
    .stop     (stop),
    .read     (read),
    .write    (write),
    .ack_in   (ack_in),
    .din      (din),
    .cmd_ack  (cmd_ack),
    .ack_out  (ack_out),
    .dout     (dout),
    .i2c_al   (i2c_al),
    .core_cmd (core_cmd),
    .core_txd (core_txd),
    .core_ack (core_ack),
    .core_rxd (core_rxd),
    .core_al  (core_al)
  );

  // Bit-controller stand-in: sample the pending command, then acknowledge it
  // for one cycle with the given rxd (and optionally arbitration lost).
  task automatic bit_step(input logic rxd, input logic al,
                          output logic [3:0] cmd, output logic txd);
    @(negedge clk);
    cmd      = core_cmd;
    txd      = core_txd;
    core_ack = 1'b1;
    core_rxd = rxd;
    core_al  = al;
    @(negedge clk);
    core_ack = 1'b0;
    core_rxd = 1'b0;
    core_al  = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    nReset = 1'b0; start = 0; stop = 0; read = 0; write = 0; ack_in = 0;
    din = 8'h00; core_ack = 0; core_rxd = 0; core_al = 0;
    repeat (3) @(negedge clk);
    obs = {core_cmd, core_txd, dout, cmd_ack, ack_out, i2c_al};
    checks++;
    if (obs !== 16'h0000) begin
      failures++; $display("FAIL reset_state got=%h exp=0000", obs);
    end
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [3:0] c; logic t; logic [7:0] rx;
    rx = 8'h6C;
    read = 1'b1; ack_in = 1'b1; din = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      bit_step(rx[7-i], 1'b0, c, t);
      checks++;
      if (c !== C_READ) begin
        failures++; $display("FAIL rd_cmd bit%0d got=%h exp=%h", i, c, C_READ);
      end
    end
    bit_step(1'b1, 1'b0, c, t);
    checks++;
    if (c !== C_WRITE || t !== 1'b1) begin
      failures++; $display("FAIL rd_ackbit cmd=%h txd=%b exp cmd=%h txd=1", c, t, C_WRITE);
    end
    checks++;
    if ({cmd_ack, dout, ack_out} !== {1'b1, 8'h6C, 1'b1}) begin
      failures++;
      $display("FAIL rd_done cmd_ack=%b dout=%h ack_out=%b exp 1/6c/1", cmd_ack, dout, ack_out);
    end
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ack !== 1'b0) begin
      failures++; $display("FAIL rd_ack_pulse cmd_ack=%b exp=0", cmd_ack);
    end
  endtask

  task automatic test_stop_only();
    logic [3:0] c; logic t;
    stop = 1'b1; din = 8'h6C;
    @(negedge clk);
    checks++;
    if ({core_cmd, cmd_ack, dout} !== {C_STOP, 1'b0, 8'h6C}) begin
      failures++;
      $display("FAIL so_issue cmd=%h cmd_ack=%b dout=%h exp %h/0/6c", core_cmd, cmd_ack, dout, C_STOP);
    end
    bit_step(1'b0, 1'b0, c, t);
    checks++;
    if ({cmd_ack, core_cmd, dout, ack_out} !== {1'b1, C_NOP, 8'h6C, 1'b1}) begin
      failures++;
      $display("FAIL so_done cmd_ack=%b cmd=%h dout=%h ack_out=%b exp 1/0/6c/1",
               cmd_ack, core_cmd, dout, ack_out);
    end
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_start();
    logic [3:0] c; logic t; logic [7:0] tx;
    tx = 8'hA5;
    start = 1'b1; write = 1'b1; din = tx;
    bit_step(1'b0, 1'b0, c, t);
    checks++;
    if (c !== C_START) begin
      failures++; $display("FAIL ws_start got=%h exp=%h", c, C_START);
    end
    for (int i = 0; i < 8; i++) begin
      bit_step(1'b0, 1'b0, c, t);
      checks++;
      if (c !== C_WRITE || t !== tx[7-i]) begin
        failures++;
        $display("FAIL ws_bit%0d cmd=%h txd=%b exp cmd=%h txd=%b", i, c, t, C_WRITE, tx[7-i]);
      end
    end
    bit_step(1'b0, 1'b0, c, t);
    checks++;
    if (c !== C_READ) begin
      failures++; $display("FAIL ws_acksample got=%h exp=%h", c, C_READ);
    end
    checks++;
    if ({cmd_ack, core_cmd, ack_out} !== {1'b1, C_NOP, 1'b0}) begin
      failures++;
      $display("FAIL ws_done cmd_ack=%b cmd=%h ack_out=%b exp 1/0/0", cmd_ack, core_cmd, ack_out);
    end
    // Request still held through the cmd_ack cycle: must not restart.
    @(negedge clk);
    checks++;
    if ({cmd_ack, core_cmd} !== {1'b0, C_NOP}) begin
      failures++;
      $display("FAIL ws_no_restart cmd_ack=%b cmd=%h exp 0/0", cmd_ack, core_cmd);
    end
    start = 1'b0; write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_stop();
    logic [3:0] c; logic t;
    write = 1'b1; stop = 1'b1; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_step(1'b0, 1'b0, c, t);
      checks++;
      if (c !== C_WRITE || t !== 1'b0) begin
        failures++; $display("FAIL wst_bit%0d cmd=%h txd=%b exp cmd=%h txd=0", i, c, t, C_WRITE);
      end
    end
    bit_step(1'b1, 1'b0, c, t);
    checks++;
    if (c !== C_READ) begin
      failures++; $display("FAIL wst_acksample got=%h exp=%h", c, C_READ);
    end
    checks++;
    if ({cmd_ack, core_cmd} !== {1'b0, C_STOP}) begin
      failures++;
      $display("FAIL wst_to_stop cmd_ack=%b cmd=%h exp 0/%h", cmd_ack, core_cmd, C_STOP);
    end
    bit_step(1'b0, 1'b0, c, t);
    checks++;
    if ({cmd_ack, ack_out, core_cmd} !== {1'b1, 1'b1, C_NOP}) begin
      failures++;
      $display("FAIL wst_done cmd_ack=%b ack_out=%b cmd=%h exp 1/1/0", cmd_ack, ack_out, core_cmd);
    end
    write = 1'b0; stop = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ack !== 1'b0) begin
      failures++; $display("FAIL wst_ack_pulse cmd_ack=%b exp=0", cmd_ack);
    end
  endtask

  task automatic test_arb_lost();
    logic [3:0] c; logic t; logic [7:0] tx;
    tx = 8'h3C;
    write = 1'b1; din = tx;
    for (int i = 0; i < 3; i++) begin
      bit_step(1'b0, 1'b0, c, t);
      checks++;
      if (c !== C_WRITE || t !== tx[7-i]) begin
        failures++; $display("FAIL al_bit%0d cmd=%h txd=%b exp %h/%b", i, c, t, C_WRITE, tx[7-i]);
      end
    end
    // 4th bit: core_al arrives together with core_ack; al must win.
    bit_step(1'b1, 1'b1, c, t);
    checks++;
    if (c !== C_WRITE || t !== tx[4]) begin
      failures++; $display("FAIL al_bit3 cmd=%h txd=%b exp %h/%b", c, t, C_WRITE, tx[4]);
    end
    checks++;
    if ({core_cmd, core_txd, i2c_al, cmd_ack, dout, ack_out} !==
        {C_NOP, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b1}) begin
      failures++;
      $display("FAIL al_abort cmd=%h txd=%b al=%b cmd_ack=%b dout=%h ack_out=%b exp 0/0/1/0/e0/1",
               core_cmd, core_txd, i2c_al, cmd_ack, dout, ack_out);
    end
    write = 1'b0;
    @(negedge clk);
    checks++;
    if ({i2c_al, cmd_ack, core_cmd} !== {1'b0, 1'b0, C_NOP}) begin
      failures++;
      $display("FAIL al_pulse al=%b cmd_ack=%b cmd=%h exp 0/0/0", i2c_al, cmd_ack, core_cmd);
    end
    // A new request is accepted after the abort.
    write = 1'b1; din = 8'h81;
    @(negedge clk);
    checks++;
    if ({core_cmd, core_txd} !== {C_WRITE, 1'b1}) begin
      failures++; $display("FAIL al_new_req cmd=%h txd=%b exp %h/1", core_cmd, core_txd, C_WRITE);
    end
    bit_step(1'b0, 1'b1, c, t);
    checks++;
    if ({i2c_al, core_cmd} !== {1'b1, C_NOP}) begin
      failures++; $display("FAIL al_second al=%b cmd=%h exp 1/0", i2c_al, core_cmd);
    end
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] c; logic t; logic [15:0] obs;
    read = 1'b1; ack_in = 1'b0; din = 8'h81;
    for (int i = 0; i < 3; i++) bit_step(1'b1, 1'b0, c, t);
    checks++;
    if ({core_cmd, dout} !== {C_READ, 8'h0F}) begin
      failures++; $display("FAIL rm_before cmd=%h dout=%h exp %h/0f", core_cmd, dout, C_READ);
    end
    nReset = 1'b0;
    @(negedge clk);
    obs = {core_cmd, core_txd, dout, cmd_ack, ack_out, i2c_al};
    checks++;
    if (obs !== 16'h0000) begin
      failures++; $display("FAIL rm_reset_state got=%h exp=0000", obs);
    end
    nReset = 1'b1; read = 1'b0;
    @(negedge clk);
    checks++;
    if (core_cmd !== C_NOP) begin
      failures++; $display("FAIL rm_idle cmd=%h exp=0", core_cmd);
    end
    // Held stop-only request across its cmd_ack cycle.
    stop = 1'b1;
    bit_step(1'b0, 1'b0, c, t);
    checks++;
    if ({c, cmd_ack} !== {C_STOP, 1'b1}) begin
      failures++; $display("FAIL rm_stop cmd=%h cmd_ack=%b exp %h/1", c, cmd_ack, C_STOP);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ack, core_cmd} !== {1'b0, C_NOP}) begin
      failures++;
      $display("FAIL rm_no_restart cmd_ack=%b cmd=%h exp 0/0", cmd_ack, core_cmd);
    end
    stop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_stop_only();
    test_write_start();
    test_write_stop();
    test_arb_lost();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
